// File: rtl/sccb_arbiter.sv
// Round-robin arbiter sharing one SCCB bridge master port between two requesters,
// with one outstanding transaction and a downstream response timeout.
module sccb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        sccb_clk,
  input  logic        sccb_reset,
  input  logic [2:0]  m0_mcmd,
  input  logic [14:0] m0_maddr,
  input  logic [7:0]  m0_mdata,
  output logic        m0_scmdaccept,
  output logic [1:0]  m0_sresp,
  output logic [7:0]  m0_sdata,
  input  logic [2:0]  m1_mcmd,
  input  logic [14:0] m1_maddr,
  input  logic [7:0]  m1_mdata,
  output logic        m1_scmdaccept,
  output logic [1:0]  m1_sresp,
  output logic [7:0]  m1_sdata,
  output logic [2:0]  s_mcmd,
  output logic [14:0] s_maddr,
  output logic [7:0]  s_mdata,
  input  logic        s_scmdaccept,
  input  logic [1:0]  s_sresp,
  input  logic [7:0]  s_sdata,
  output logic        busy,
  output logic        last_grant,
  output logic [1:0]  err_flags
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] FAILRSP = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             winner;

  logic             req0;
  logic             req1;
  logic             grantSel;
  logic [2:0]       grantCmd;
  logic [14:0]      grantAddr;
  logic [7:0]       grantData;
  logic             cmdSupported;

  logic [1:0]       rspCode;
  logic [7:0]       rspData;
  logic             timeoutHit;

  always_comb begin
    req0         = (m0_mcmd != 3'd0);
    req1         = (m1_mcmd != 3'd0);
    // Contention goes to whoever was not granted last; otherwise the lone requester.
    grantSel     = (req0 && req1) ? ~last_grant : req1;
    grantCmd     = grantSel ? m1_mcmd  : m0_mcmd;
    grantAddr    = grantSel ? m1_maddr : m0_maddr;
    grantData    = grantSel ? m1_mdata : m0_mdata;
    cmdSupported = (grantCmd == 3'd1) || (grantCmd == 3'd2);
  end

  // A downstream response on the expiry cycle takes priority over the timeout.
  always_comb begin
    rspCode    = '0;
    rspData    = '0;
    timeoutHit = 1'b0;
    case (state)
      WAIT: begin
        if (s_sresp != 2'd0) begin
          rspCode = s_sresp;
          rspData = s_sdata;
        end else if (cnt == CNT_MAX) begin
          rspCode    = 2'd3;
          timeoutHit = 1'b1;
        end
      end
      FAILRSP: rspCode = 2'd2;
      default: ;
    endcase
  end

  always_ff @(posedge sccb_clk) begin
    if (sccb_reset) begin
      state         <= IDLE;
      cnt           <= '0;
      winner        <= 1'b0;
      m0_scmdaccept <= 1'b0;
      m0_sresp      <= '0;
      m0_sdata      <= '0;
      m1_scmdaccept <= 1'b0;
      m1_sresp      <= '0;
      m1_sdata      <= '0;
      s_mcmd        <= '0;
      s_maddr       <= '0;
      s_mdata       <= '0;
      busy          <= 1'b0;
      last_grant    <= 1'b1;
      err_flags     <= '0;
    end else begin
      m0_scmdaccept <= 1'b0;
      m1_scmdaccept <= 1'b0;
      m0_sresp      <= winner ? 2'd0 : rspCode;
      m0_sdata      <= winner ? 8'd0 : rspData;
      m1_sresp      <= winner ? rspCode : 2'd0;
      m1_sdata      <= winner ? rspData : 8'd0;

      if ((s_sresp != 2'd0) && (state != WAIT))
        err_flags[1] <= 1'b1;
      if (timeoutHit)
        err_flags[0] <= 1'b1;

      case (state)
        IDLE: begin
          if (req0 || req1) begin
            winner        <= grantSel;
            last_grant    <= grantSel;
            m0_scmdaccept <= ~grantSel;
            m1_scmdaccept <= grantSel;
            s_maddr       <= grantAddr;
            s_mdata       <= grantData;
            busy          <= 1'b1;
            if (cmdSupported) begin
              s_mcmd <= grantCmd;
              state  <= ISSUE;
            end else begin
              state  <= FAILRSP;
            end
          end
        end
        ISSUE: begin
          if (s_scmdaccept) begin
            s_mcmd <= '0;
            cnt    <= '0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (rspCode != 2'd0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FAILRSP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_arbiter.sv
// Cycle-by-cycle vector table for sccb_arbiter plus hand-written multi-cycle sequences.
module tb_sccb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  m0Cmd = '0, m1Cmd = '0;
  logic [14:0] m0Addr = 15'h0012, m1Addr = 15'h0034;
  logic [7:0]  m0Data = 8'h80, m1Data = 8'h11;
  logic        m0Acc, m1Acc;
  logic [1:0]  m0Rsp, m1Rsp;
  logic [7:0]  m0Sd, m1Sd;
  logic [2:0]  sCmd;
  logic [14:0] sAddr;
  logic [7:0]  sData;
  logic        sAcc = 1'b0;
  logic [1:0]  sRsp = '0;
  logic [7:0]  sSd = '0;
  logic        busy, lastGrant;
  logic [1:0]  errFlags;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sccb_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .sccb_clk(clk), .sccb_reset(rst),
    .m0_mcmd(m0Cmd), .m0_maddr(m0Addr), .m0_mdata(m0Data),
    .m0_scmdaccept(m0Acc), .m0_sresp(m0Rsp), .m0_sdata(m0Sd),
    .m1_mcmd(m1Cmd), .m1_maddr(m1Addr), .m1_mdata(m1Data),
    .m1_scmdaccept(m1Acc), .m1_sresp(m1Rsp), .m1_sdata(m1Sd),
    .s_mcmd(sCmd), .s_maddr(sAddr), .s_mdata(sData),
    .s_scmdaccept(sAcc), .s_sresp(sRsp), .s_sdata(sSd),
    .busy(busy), .last_grant(lastGrant), .err_flags(errFlags)
  );

  typedef struct {
    logic       rst;
    logic [2:0] c0, c1;
    logic       acc;
    logic [1:0] rsp;
    logic [7:0] sd;
    logic       a0;
    logic [1:0] r0;
    logic [7:0] d0;
    logic       a1;
    logic [1:0] r1;
    logic [7:0] d1;
    logic [2:0] sc;
    logic       bz, lg;
    logic [1:0] ef;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, input logic [2:0] c0, c1, input logic acc,
                             input logic [1:0] rsp, input logic [7:0] sd,
                             input logic a0, input logic [1:0] r0, input logic [7:0] d0,
                             input logic a1, input logic [1:0] r1, input logic [7:0] d1,
                             input logic [2:0] sc, input logic bz, lg, input logic [1:0] ef);
    vec_t x;
    x.rst = r; x.c0 = c0; x.c1 = c1; x.acc = acc; x.rsp = rsp; x.sd = sd;
    x.a0 = a0; x.r0 = r0; x.d0 = d0; x.a1 = a1; x.r1 = r1; x.d1 = d1;
    x.sc = sc; x.bz = bz; x.lg = lg; x.ef = ef;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleRow(input logic lg, input logic [1:0] ef);
    vecs.push_back(v(0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,lg,ef));
  endtask

  task automatic waitRows(input int n, input logic lg, input logic [1:0] ef);
    for (int i = 0; i < n; i++) vecs.push_back(v(0,0,0,0,0,0, 0,0,0,0,0,0, 0,1,lg,ef));
  endtask

  task automatic resetRow();
    vecs.push_back(v(1,0,0,0,0,0, 0,0,0,0,0,0, 0,0,1,0));
  endtask

  initial begin
    int n;
    logic [1:0] seen;

    resetRow();
    // req0 WR, bridge accepts on third ISSUE cycle, DVA seven cycles into WAIT
    vecs.push_back(v(0,1,0,0,0,0, 1,0,0,0,0,0, 1,1,0,0));
    vecs.push_back(v(0,1,0,0,0,0, 0,0,0,0,0,0, 1,1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 0,0,0,0,0,0, 1,1,0,0));
    vecs.push_back(v(0,0,0,1,0,0, 0,0,0,0,0,0, 0,1,0,0));
    waitRows(6, 0, 0);
    vecs.push_back(v(0,0,0,0,1,8'h00, 0,1,0,0,0,0, 0,0,0,0));
    idleRow(0, 0);
    // simultaneous RD requests alternate grants
    resetRow();
    vecs.push_back(v(0,2,2,0,0,0,     1,0,0,0,0,0,     2,1,0,0));
    vecs.push_back(v(0,2,2,1,0,0,     0,0,0,0,0,0,     0,1,0,0));
    vecs.push_back(v(0,0,2,0,1,8'h5A, 0,1,8'h5A,0,0,0, 0,0,0,0));
    vecs.push_back(v(0,0,2,0,0,0,     0,0,0,1,0,0,     2,1,1,0));
    vecs.push_back(v(0,0,2,1,0,0,     0,0,0,0,0,0,     0,1,1,0));
    vecs.push_back(v(0,0,0,0,1,8'h5A, 0,0,0,0,1,8'h5A, 0,0,1,0));
    vecs.push_back(v(0,2,2,0,0,0,     1,0,0,0,0,0,     2,1,0,0));
    vecs.push_back(v(0,2,2,1,0,0,     0,0,0,0,0,0,     0,1,0,0));
    vecs.push_back(v(0,0,2,0,1,8'h5A, 0,1,8'h5A,0,0,0, 0,0,0,0));
    vecs.push_back(v(0,2,2,0,0,0,     0,0,0,1,0,0,     2,1,1,0));
    vecs.push_back(v(0,2,2,1,0,0,     0,0,0,0,0,0,     0,1,1,0));
    vecs.push_back(v(0,0,0,0,1,8'h5A, 0,0,0,0,1,8'h5A, 0,0,1,0));
    // unsupported command from req1
    vecs.push_back(v(0,0,3,0,0,0, 0,0,0,1,0,0, 0,1,1,0));
    vecs.push_back(v(0,0,3,0,0,0, 0,0,0,0,2,0, 0,0,1,0));
    idleRow(1, 0);
    // timeout, then a late orphan DVA
    vecs.push_back(v(0,1,0,0,0,0, 1,0,0,0,0,0, 1,1,0,0));
    vecs.push_back(v(0,1,0,1,0,0, 0,0,0,0,0,0, 0,1,0,0));
    waitRows(7, 0, 0);
    vecs.push_back(v(0,0,0,0,0,0, 0,3,0,0,0,0, 0,0,0,1));
    vecs.push_back(v(0,0,0,0,1,0, 0,0,0,0,0,0, 0,0,0,3));
    idleRow(0, 3);
    // DVA on the expiry cycle wins over the timeout
    resetRow();
    vecs.push_back(v(0,1,0,0,0,0, 1,0,0,0,0,0, 1,1,0,0));
    vecs.push_back(v(0,1,0,1,0,0, 0,0,0,0,0,0, 0,1,0,0));
    waitRows(7, 0, 0);
    vecs.push_back(v(0,0,0,0,1,8'h77, 0,1,8'h77,0,0,0, 0,0,0,0));
    idleRow(0, 0);
    // reset during WAIT, response after reset is an orphan, req1 then completes
    vecs.push_back(v(0,2,0,0,0,0, 1,0,0,0,0,0, 2,1,0,0));
    vecs.push_back(v(0,2,0,1,0,0, 0,0,0,0,0,0, 0,1,0,0));
    waitRows(1, 0, 0);
    resetRow();
    vecs.push_back(v(0,0,0,0,1,8'h5A, 0,0,0,0,0,0, 0,0,1,2));
    vecs.push_back(v(0,0,1,0,0,0,     0,0,0,1,0,0, 1,1,1,2));
    vecs.push_back(v(0,0,1,1,0,0,     0,0,0,0,0,0, 0,1,1,2));
    vecs.push_back(v(0,0,0,0,1,8'h33, 0,0,0,0,1,8'h33, 0,0,1,2));
    idleRow(1, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; m0Cmd = vecs[i].c0; m1Cmd = vecs[i].c1;
      sAcc = vecs[i].acc; sRsp = vecs[i].rsp; sSd = vecs[i].sd;
      tick();
      chk($sformatf("row%0d m0_scmdaccept", i), 32'(m0Acc), 32'(vecs[i].a0));
      chk($sformatf("row%0d m0_sresp", i), 32'(m0Rsp), 32'(vecs[i].r0));
      chk($sformatf("row%0d m0_sdata", i), 32'(m0Sd), 32'(vecs[i].d0));
      chk($sformatf("row%0d m1_scmdaccept", i), 32'(m1Acc), 32'(vecs[i].a1));
      chk($sformatf("row%0d m1_sresp", i), 32'(m1Rsp), 32'(vecs[i].r1));
      chk($sformatf("row%0d m1_sdata", i), 32'(m1Sd), 32'(vecs[i].d1));
      chk($sformatf("row%0d s_mcmd", i), 32'(sCmd), 32'(vecs[i].sc));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].bz));
      chk($sformatf("row%0d last_grant", i), 32'(lastGrant), 32'(vecs[i].lg));
      chk($sformatf("row%0d err_flags", i), 32'(errFlags), 32'(vecs[i].ef));
      if (vecs[i].sc != 3'd0) begin
        chk($sformatf("row%0d s_maddr", i), 32'(sAddr), vecs[i].lg ? 32'h34 : 32'h12);
        chk($sformatf("row%0d s_mdata", i), 32'(sData), vecs[i].lg ? 32'h11 : 32'h80);
      end
    end
    rst = 1'b0; m0Cmd = '0; m1Cmd = '0; sAcc = 1'b0; sRsp = '0; sSd = '0;

    // ISSUE has no timeout: command held for 20 cycles, then reset drops it
    m0Cmd = 3'd1;
    tick();
    chk("issueHold accept", 32'(m0Acc), 32'd1);
    m0Cmd = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("issueHold c%0d s_mcmd", i), 32'(sCmd), 32'd1);
      chk($sformatf("issueHold c%0d m0_sresp", i), 32'(m0Rsp), 32'd0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("issueReset s_mcmd", 32'(sCmd), 32'd0);
    chk("issueReset busy", 32'(busy), 32'd0);
    chk("issueReset last_grant", 32'(lastGrant), 32'd1);
    chk("issueReset err_flags", 32'(errFlags), 32'd0);

    // bounded wait for the timeout response, counted from entry into WAIT
    m0Cmd = 3'd2;
    tick();
    sAcc = 1'b1;
    tick();
    sAcc = 1'b0; m0Cmd = '0;
    n = 0; seen = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (m0Rsp != 2'd0) begin
        seen = m0Rsp;
        break;
      end
    end
    chk("timeoutWait cycles", 32'(n), 32'd8);
    chk("timeoutWait sresp", 32'(seen), 32'd3);
    chk("timeoutWait err_flags", 32'(errFlags), 32'd1);
    chk("timeoutWait m1_sresp", 32'(m1Rsp), 32'd0);
    tick();
    chk("timeoutWait pulse", 32'(m0Rsp), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
